// File: rtl/uart_tx_fifo.sv
// UART transmitter (start, 8 data bits LSB first, STOP_BITS stop bits) fed from a small byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit(s).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 100,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       CLOCK,
    input  logic       reset,
    input  logic [7:0] dataToSend,
    input  logic       sendData,
    output logic       TX,
    output logic       busy,
    output logic       fifoFull,
    output logic       overflow,
    output logic       txDone
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [9:0]       LAST_TICK = 10'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] DEPTH     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } stateT;

    stateT            state, stateNext;
    logic [9:0]       bitCnt, bitCntNext;
    logic [2:0]       bitIdx, bitIdxNext;
    logic [7:0]       shiftReg;
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [CNT_W-1:0] count;
    logic             pushOk, pop, bitEnd, txNext;
    logic [7:0]       popData;

    assign pushOk  = sendData && (count < DEPTH);
    assign bitEnd  = (bitCnt == LAST_TICK);
    // An empty FIFO can only be popped at the end of STOP, and then the byte is the one being written now.
    assign popData = (count == '0) ? dataToSend : fifoMem[rdPtr];

    // NOTE: the storage array is deliberately left unreset; pointers and count alone define its contents.
    always_ff @(posedge CLOCK) begin
        if (pushOk) fifoMem[wrPtr] <= dataToSend;
    end

    always_ff @(posedge CLOCK) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (pop)    rdPtr <= rdPtr + 1'b1;
            if (pushOk && !pop)      count <= count + 1'b1;
            else if (pop && !pushOk) count <= count - 1'b1;
            if (sendData && !pushOk) overflow <= 1'b1;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK) begin
        if (reset) begin
            state    <= IDLE;
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
            TX       <= 1'b1;
        end else begin
            state  <= stateNext;
            bitCnt <= bitCntNext;
            bitIdx <= bitIdxNext;
            TX     <= txNext;
            if (pop) shiftReg <= popData;
        end
    end

    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    always_comb begin
        stateNext  = state;
        bitCntNext = bitEnd ? '0 : bitCnt + 1'b1;
        bitIdxNext = bitIdx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                bitCntNext = '0;
                if (count != '0) begin
                    pop       = 1'b1;
                    stateNext = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    stateNext  = DATA;
                    bitIdxNext = '0;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    bitIdxNext = bitIdx + 1'b1;
                    if (bitIdx == 3'd7) begin
                        bitIdxNext = '0;
`ifdef UART_TX_PARITY_EN
                        stateNext  = PARITY;
`else
                        stateNext  = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    stateNext  = STOP;
                    bitIdxNext = '0;
                end
            end
`endif
            STOP: begin
                if (bitEnd) begin
                    bitIdxNext = bitIdx + 1'b1;
                    if (bitIdx == LAST_STOP) begin
                        bitIdxNext = '0;
                        if (count != '0 || pushOk) begin
                            pop       = 1'b1;
                            stateNext = START;
                        end else begin
                            stateNext = IDLE;
                        end
                    end
                end
            end
            default: begin
                stateNext  = IDLE;
                bitCntNext = '0;
                bitIdxNext = '0;
            end
        endcase
    end

    always_comb begin
        txNext = 1'b1;
        case (stateNext)
            START:   txNext = 1'b0;
            DATA:    txNext = shiftReg[bitIdxNext];
`ifdef UART_TX_PARITY_EN
            PARITY:  txNext = ^shiftReg;
`endif
            default: txNext = 1'b1;
        endcase
        busy     = (state != IDLE) || (count != '0);
        fifoFull = (count == DEPTH);
        txDone   = (state == STOP) && bitEnd && (bitIdx == LAST_STOP);
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: two instances (default timing, and 4 clocks/bit with 2 stop bits) checked
// every cycle against a frame-position model, plus literal checks of the key timing points.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int CPB0 = 100, SB0 = 1, DEP0 = 4;
    localparam int CPB1 = 4,   SB1 = 2, DEP1 = 2;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FLEN0 = (10 + PAR + SB0 - 1) * CPB0;
    localparam int FLEN1 = (10 + PAR + SB1 - 1) * CPB1;

    logic       clk = 1'b0;
    logic       reset0 = 1'b1, send0 = 1'b0, reset1 = 1'b1, send1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       tx0, busy0, full0, ovf0, done0;
    logic       tx1, busy1, full1, ovf1, done1;

    int vectors = 0, miscompares = 0, cyc = 0;
    int doneCnt0 = 0, doneCnt1 = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB0), .STOP_BITS(SB0), .FIFO_DEPTH(DEP0)) dut0 (
        .CLOCK(clk), .reset(reset0), .dataToSend(data0), .sendData(send0),
        .TX(tx0), .busy(busy0), .fifoFull(full0), .overflow(ovf0), .txDone(done0));

    uart_tx_fifo #(.CLKS_PER_BIT(CPB1), .STOP_BITS(SB1), .FIFO_DEPTH(DEP1)) dut1 (
        .CLOCK(clk), .reset(reset1), .dataToSend(data1), .sendData(send1),
        .TX(tx1), .busy(busy1), .fifoFull(full1), .overflow(ovf1), .txDone(done1));

    // Model: a byte queue plus the in-flight byte and the cycle position inside its frame.
    logic [7:0] q0[$], q1[$];
    logic       active[2], mOvf[2], seen[2];
    int         pos[2];
    logic [7:0] fbyte[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            active[i] = 1'b0; mOvf[i] = 1'b0; seen[i] = 1'b0; pos[i] = 0; fbyte[i] = 8'h00;
        end
    end

    function automatic int cpbOf(input int i);   return (i == 0) ? CPB0 : CPB1;   endfunction
    function automatic int depthOf(input int i); return (i == 0) ? DEP0 : DEP1;   endfunction
    function automatic int flenOf(input int i);  return (i == 0) ? FLEN0 : FLEN1; endfunction
    function automatic int qsize(input int i);   return (i == 0) ? q0.size() : q1.size(); endfunction

    function automatic logic [7:0] qpop(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void qpush(input int i, input logic [7:0] b);
        if (i == 0) q0.push_back(b);
        else        q1.push_back(b);
    endfunction

    function automatic void qclear(input int i);
        if (i == 0) q0.delete();
        else        q1.delete();
    endfunction

    function automatic void model_step(input int i, input logic r, input logic s, input logic [7:0] d);
        logic acc;
        if (r) begin
            qclear(i);
            active[i] = 1'b0; pos[i] = 0; mOvf[i] = 1'b0; seen[i] = 1'b1;
        end else begin
            acc = s && (qsize(i) < depthOf(i));
            if (s && !acc) mOvf[i] = 1'b1;
            if (active[i]) begin
                pos[i]++;
                if (pos[i] == flenOf(i)) begin
                    pos[i] = 0;
                    if (qsize(i) > 0) fbyte[i] = qpop(i);
                    else if (acc) begin fbyte[i] = d; acc = 1'b0; end
                    else active[i] = 1'b0;
                end
            end else if (qsize(i) > 0) begin
                fbyte[i] = qpop(i); pos[i] = 0; active[i] = 1'b1;
            end
            if (acc) qpush(i, d);
        end
    endfunction

    function automatic logic exp_tx(input int i);
        int b;
        if (!active[i]) return 1'b1;
        b = pos[i] / cpbOf(i);
        if (b == 0) return 1'b0;
        if (b <= 8) return fbyte[i][b-1];
        if (PAR == 1 && b == 9) return ^fbyte[i];
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int i); return active[i] || qsize(i) > 0; endfunction
    function automatic logic exp_full(input int i); return qsize(i) == depthOf(i); endfunction
    function automatic logic exp_done(input int i); return active[i] && pos[i] == flenOf(i) - 1; endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step(0, reset0, send0, data0);
        model_step(1, reset1, send1, data1);
    end

    always @(negedge clk) begin
        if (seen[0]) begin
            check("dut0 TX", tx0, exp_tx(0));
            check("dut0 busy", busy0, exp_busy(0));
            check("dut0 fifoFull", full0, exp_full(0));
            check("dut0 overflow", ovf0, mOvf[0]);
            check("dut0 txDone", done0, exp_done(0));
            if (done0) doneCnt0++;
        end
        if (seen[1]) begin
            check("dut1 TX", tx1, exp_tx(1));
            check("dut1 busy", busy1, exp_busy(1));
            check("dut1 fifoFull", full1, exp_full(1));
            check("dut1 overflow", ovf1, mOvf[1]);
            check("dut1 txDone", done1, exp_done(1));
            if (done1) doneCnt1++;
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle0(input int budget);
        int n = 0;
        while (busy0 && n < budget) begin edges(1); n++; end
        check("dut0 drains within budget", busy0, 1'b0);
    endtask

    task automatic wait_idle1(input int budget);
        int n = 0;
        while (busy1 && n < budget) begin edges(1); n++; end
        check("dut1 drains within budget", busy1, 1'b0);
    endtask

    task automatic seq0();
        int d;
        edges(3);
        reset0 = 1'b0;
        check("rst TX", tx0, 1'b1);
        check("rst busy", busy0, 1'b0);
        check("rst fifoFull", full0, 1'b0);
        check("rst overflow", ovf0, 1'b0);
        check("rst txDone", done0, 1'b0);
        edges(5);

        // Single 0x55 frame; later data changes must not disturb it.
        send0 = 1'b1; data0 = 8'h55; edges(1);
        send0 = 1'b0; data0 = 8'hC3;
        check("t1 queued busy", busy0, 1'b1);
        check("t1 idle before start", tx0, 1'b1);
        edges(1);   check("t1 start bit", tx0, 1'b0);
        edges(100); check("t1 data bit0", tx0, 1'b1);
        edges(100); check("t1 data bit1", tx0, 1'b0);
        edges(FLEN0 - 201);
        check("t1 txDone last stop cycle", done0, 1'b1);
        check("t1 stop level", tx0, 1'b1);
        edges(1);
        check("t1 busy after frame", busy0, 1'b0);
        check("t1 txDone one cycle", done0, 1'b0);

        // Back-to-back frames: second start bit exactly one frame after the first.
        edges(3);
        send0 = 1'b1; data0 = 8'hA3; edges(1);
        data0 = 8'h0F; edges(1);
        send0 = 1'b0;
        d = doneCnt0;
        check("t2 first start", tx0, 1'b0);
        edges(FLEN0 - 1);
        check("t2 first stop end", tx0, 1'b1);
        check("t2 first txDone", done0, 1'b1);
        edges(1);
        check("t2 second start", tx0, 1'b0);
        wait_idle0(3 * FLEN0);
        check("t2 two txDone pulses", doneCnt0 - d, 2);

        // Six writes in six cycles into a depth-4 FIFO.
        send0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            data0 = 8'($urandom);
            edges(1);
            if (k == 3) check("t3 not full after 4th", full0, 1'b0);
            if (k == 4) check("t3 full after 5th", full0, 1'b1);
            if (k == 5) check("t3 overflow after 6th", ovf0, 1'b1);
        end
        send0 = 1'b0;
        wait_idle0(7 * FLEN0);
        check("t3 overflow sticky", ovf0, 1'b1);

        // Reset during data bit 3 with two bytes still queued.
        reset0 = 1'b1; edges(1); reset0 = 1'b0;
        check("t4 reset clears overflow", ovf0, 1'b0);
        send0 = 1'b1; data0 = 8'hF7; edges(1);
        data0 = 8'h12; edges(1);
        data0 = 8'h34; edges(1);
        send0 = 1'b0;
        edges(448);
        check("t4 mid data bit3 level", tx0, 1'b0);
        reset0 = 1'b1; edges(1); reset0 = 1'b0;
        check("t4 TX idle after reset", tx0, 1'b1);
        check("t4 busy cleared", busy0, 1'b0);
        d = doneCnt0;
        edges(1200);
        check("t4 no frames after reset", busy0, 1'b0);
        check("t4 no txDone after reset", doneCnt0 - d, 0);

`ifdef UART_TX_PARITY_EN
        send0 = 1'b1; data0 = 8'h07; edges(1); send0 = 1'b0;
        edges(1 + 900 + 50);
        check("t6 parity bit of 0x07", tx0, 1'b1);
        edges(FLEN0 - 951);
        check("t6 txDone at 1100", done0, 1'b1);
        wait_idle0(2 * FLEN0);
`endif
    endtask

    task automatic seq1();
        int rates[4] = '{1, 3, 6, 20};
        edges(3);
        reset1 = 1'b0;
        edges(2);

        // 0xFF with 4 clocks per bit and two stop bits.
        send1 = 1'b1; data1 = 8'hFF; edges(1); send1 = 1'b0;
        edges(4);  check("t5 start last cycle", tx1, 1'b0);
        edges(1);  check("t5 first data cycle", tx1, 1'b1);
        edges(FLEN1 - 6);
        check("t5 no early txDone", done1, 1'b0);
        check("t5 stop level", tx1, 1'b1);
        edges(1);  check("t5 txDone final stop cycle", done1, 1'b1);
        edges(1);  check("t5 idle after frame", busy1, 1'b0);

        for (int c = 0; c < 4000; c++) begin
            send1  = ($urandom_range(0, 99) < rates[(c / 500) % 4]);
            data1  = 8'($urandom);
            reset1 = ($urandom_range(0, 999) == 0);
            edges(1);
        end
        send1 = 1'b0; reset1 = 1'b0;
        wait_idle1((DEP1 + 2) * FLEN1);
    endtask

    initial begin
        fork
            seq0();
            seq1();
        join
        edges(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
